// File: rtl/lpc_pkg.sv
// Shared constants and FSM encoding for the lpc_synth all-pole synthesis filter.
package lpc_pkg;
  localparam int SAMPLE_FRAC = 15;
  localparam int COEF_FRAC   = 12;
  localparam int RND_CONST   = 1 << (COEF_FRAC - 1);
  localparam int SAT_MAX     = 32767;
  localparam int SAT_MIN     = -32768;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
endpackage

// File: rtl/lpc_coef_bank.sv
// Shadow/active coefficient register file with deferred swap; read port indexed by tap.
module lpc_coef_bank
  import lpc_pkg::*;
#(
  parameter int ORDER = 10,
  parameter int CW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [3:0]    i_addr,
  input  logic [CW-1:0] i_data,
  input  logic          i_swap,
  input  logic          i_swap_ok,
  input  logic [3:0]    i_rd_idx,
  output logic [CW-1:0] o_coef,
  output logic          o_swap_pend
);

  logic [ORDER-1:0][CW-1:0] r_shadow, r_active;
  logic                     r_pend;
  logic                     w_do_swap;

  assign w_do_swap   = r_pend & i_swap_ok;
  assign o_swap_pend = r_pend;

  // A write landing in the swap cycle is forwarded so the copied bank includes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
    end else begin
      for (int i = 0; i < ORDER; i++) begin
        if (i_we && i_addr == 4'(i)) r_shadow[i] <= i_data;
        if (w_do_swap) r_active[i] <= (i_we && i_addr == 4'(i)) ? i_data : r_shadow[i];
      end
      r_pend <= w_do_swap ? 1'b0 : (r_pend | i_swap);
    end
  end

  always_comb begin
    o_coef = '0;
    for (int i = 0; i < ORDER; i++)
      if (i_rd_idx == 4'(i)) o_coef = r_active[i];
  end

endmodule

// File: rtl/lpc_synth.sv
// Order-P direct-form all-pole LPC synthesis filter, time-multiplexed over one multiplier.
// Define LPC_SYNTH_GAIN_EN to add a Q4.12 gain port (one extra MAC cycle of latency).
module lpc_synth
  import lpc_pkg::*;
#(
  parameter int ORDER = 10,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int AW    = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          coef_swap,
  input  logic          hist_clr,
`ifdef LPC_SYNTH_GAIN_EN
  input  logic [CW-1:0] gain,
`endif
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          swap_pend
);

  localparam logic signed [AW-1:0] L_MAX = AW'(SAT_MAX);
  localparam logic signed [AW-1:0] L_MIN = AW'(SAT_MIN);

  state_t                   r_state;
  logic [4:0]               r_k;
  logic signed [AW-1:0]     r_acc;
  logic [ORDER-1:0][DW-1:0] r_hist;
  logic                     r_clr_pend, r_in_ready, r_out_valid;
  logic [DW-1:0]            r_out_data;

  logic                     w_accept, w_clr;
  logic [CW-1:0]            w_coef;
  logic [DW-1:0]            w_hist_k, w_sat;
  logic signed [CW-1:0]     w_mul_c;
  logic signed [DW-1:0]     w_mul_s;
  logic signed [CW+DW-1:0]  w_prod;
  logic signed [AW-1:0]     w_rnd, w_shr;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_clr     = (r_state == IDLE) && (hist_clr || r_clr_pend);
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Bank swaps only in an idle cycle with no accept, so a sample never sees mixed banks.
  lpc_coef_bank #(.ORDER(ORDER), .CW(CW)) u_bank (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_we       (coef_we),
    .i_addr     (coef_addr),
    .i_data     (coef_data),
    .i_swap     (coef_swap),
    .i_swap_ok  ((r_state == IDLE) && !in_valid),
    .i_rd_idx   (4'(r_k - 5'd1)),
    .o_coef     (w_coef),
    .o_swap_pend(swap_pend)
  );

  always_comb begin
    w_hist_k = '0;
    for (int i = 0; i < ORDER; i++)
      if (r_k == 5'(i + 1)) w_hist_k = r_hist[i];
  end

`ifdef LPC_SYNTH_GAIN_EN
  logic [DW-1:0] r_x;
  logic [CW-1:0] r_gain;
  // Tap 0 reuses the multiplier for x*gain before the feedback taps.
  assign w_mul_c = (r_k == 5'd0) ? r_gain : w_coef;
  assign w_mul_s = (r_k == 5'd0) ? r_x : w_hist_k;
`else
  assign w_mul_c = w_coef;
  assign w_mul_s = w_hist_k;
`endif

  assign w_prod = w_mul_c * w_mul_s;
  assign w_rnd  = r_acc + AW'(RND_CONST);
  assign w_shr  = w_rnd >>> COEF_FRAC;

  always_comb begin
    if (w_shr > L_MAX)      w_sat = DW'(SAT_MAX);
    else if (w_shr < L_MIN) w_sat = DW'(SAT_MIN);
    else                    w_sat = w_shr[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_hist      <= '0;
      r_clr_pend  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef LPC_SYNTH_GAIN_EN
      r_x         <= '0;
      r_gain      <= '0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      if (hist_clr && r_state != IDLE) r_clr_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_clr) begin
            r_hist     <= '0;
            r_clr_pend <= 1'b0;
          end
          if (w_accept) begin
`ifdef LPC_SYNTH_GAIN_EN
            r_x     <= in_data;
            r_gain  <= gain;
            r_acc   <= '0;
            r_k     <= 5'd0;
`else
            r_acc   <= {{(AW-DW-COEF_FRAC){in_data[DW-1]}}, in_data, {COEF_FRAC{1'b0}}};
            r_k     <= 5'd1;
`endif
            r_in_ready <= 1'b0;
            r_state    <= MAC;
          end
        end
        MAC: begin
          r_acc <= r_acc + {{(AW-CW-DW){w_prod[CW+DW-1]}}, w_prod};
          r_k   <= r_k + 5'd1;
          if (r_k == 5'(ORDER)) r_state <= OUT;
        end
        OUT: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
          r_hist      <= {r_hist[ORDER-2:0], w_sat};
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
